// File: rtl/spi_reg_slave.sv
// rtl/spi_reg_slave.sv - SPI-clocked register file slave with streaming read/write
module spi_reg_slave #(
  parameter int              ADDR_W    = 7,
  parameter int              DATA_W    = 8,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter bit              STREAM_EN = 1'b1,
  parameter bit              ADDR_DESC = 1'b0,
  parameter bit              LSB_FIRST = 1'b0
) (
  input  logic              o_sclk,
  input  logic              rst_n,
  input  logic              o_sen_n,
  input  logic              o_sda,
  input  logic              o_sda_dir,
  output logic              sda_out,
  output logic              sda_oe,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic              frame_err,
  output logic              dir_err
);

  localparam int DEPTH   = 1 << ADDR_W;
  localparam int CNT_MAX = (ADDR_W + 1 > DATA_W) ? ADDR_W + 1 : DATA_W;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, INSTR, WDATA, RDATA} state_t;

  state_t            state, state_next;
  logic [CW-1:0]     bit_cnt, cnt_next, last_cnt;
  logic [ADDR_W-1:0] addr, addr_ins, addr_step, rd_addr;
  logic [DATA_W-1:0] wr_sr, wdata_next, rd_sr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              rw_q, done, instr_done, word_done, wr_fire, rd_load;
  logic              rd_bit, out_bit, frame_rst_n;
  int                a_pos, d_pos;

  // Frame state is held in reset whenever chip select is inactive.
  assign frame_rst_n = rst_n & ~o_sen_n;
  assign addr_step   = ADDR_DESC ? addr - ADDR_W'(1) : addr + ADDR_W'(1);
  assign wr_fire     = (state == WDATA) & word_done;
  assign rd_load     = (instr_done & rw_q) | ((state == RDATA) & word_done & STREAM_EN);
  assign rd_addr     = instr_done ? addr_ins : addr_step;
  assign sda_oe      = (state == RDATA) & ~o_sen_n & o_sda_dir;
  assign sda_out     = sda_oe & out_bit;
  assign dbg_data    = mem[dbg_addr];

  // Bit positions inside the address and data fields for the current count.
  always_comb begin
    a_pos = LSB_FIRST ? int'(bit_cnt) - 1 : ADDR_W - int'(bit_cnt);
    d_pos = LSB_FIRST ? int'(bit_cnt) : DATA_W - 1 - int'(bit_cnt);
    rd_bit = 1'b0;
    for (int i = 0; i < ADDR_W; i++) addr_ins[i] = (a_pos == i) ? o_sda : addr[i];
    for (int i = 0; i < DATA_W; i++) begin
      wdata_next[i] = (d_pos == i) ? o_sda : wr_sr[i];
      if (d_pos == i) rd_bit = rd_sr[i];
    end
  end

  always_ff @(posedge o_sclk or negedge frame_rst_n) begin
    if (!frame_rst_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
    end else begin
      state   <= state_next;
      bit_cnt <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = bit_cnt;
    instr_done = 1'b0;
    word_done  = 1'b0;
    case (state)
      IDLE: begin
        state_next = INSTR;
        cnt_next   = CW'(1);
      end
      INSTR: begin
        if (bit_cnt == CW'(ADDR_W)) begin
          instr_done = 1'b1;
          cnt_next   = '0;
          state_next = rw_q ? RDATA : WDATA;
        end else begin
          cnt_next = bit_cnt + 1'b1;
        end
      end
      WDATA, RDATA: begin
        if (!done) begin
          if (bit_cnt == CW'(DATA_W - 1)) begin
            word_done = 1'b1;
            cnt_next  = '0;
          end else begin
            cnt_next = bit_cnt + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge o_sclk or negedge frame_rst_n) begin
    if (!frame_rst_n) begin
      rw_q  <= 1'b0;
      addr  <= '0;
      wr_sr <= '0;
      rd_sr <= '0;
      done  <= 1'b0;
    end else begin
      if (state == IDLE) rw_q <= o_sda;
      if (state == INSTR) addr <= addr_ins;
      if (state == WDATA && !done) wr_sr <= wdata_next;
      if (word_done) begin
        if (STREAM_EN) addr <= addr_step;
        else           done <= 1'b1;
      end
      if (rd_load) rd_sr <= mem[rd_addr];
    end
  end

  // Read data changes on the falling edge so the master samples it stable.
  always_ff @(negedge o_sclk or negedge frame_rst_n) begin
    if (!frame_rst_n) out_bit <= 1'b0;
    else              out_bit <= rd_bit;
  end

  always_ff @(posedge o_sclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= RESET_VAL;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      frame_err <= 1'b0;
      dir_err   <= 1'b0;
      last_cnt  <= '0;
    end else begin
      wr_strobe <= wr_fire;
      if (wr_fire) begin
        mem[addr] <= wdata_next;
        wr_addr   <= addr;
        wr_data   <= wdata_next;
      end
      if (!o_sen_n) begin
        last_cnt <= cnt_next;
        if (state == IDLE && last_cnt != '0) frame_err <= 1'b1;
      end
      if (state == RDATA && !o_sda_dir) dir_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spi_reg_slave.sv
// tb/tb_spi_reg_slave.sv - self-checking bench for spi_reg_slave
module tb_spi_reg_slave;

  typedef struct packed {
    logic [1:0]  k;
    logic [15:0] a;
    logic [31:0] d;
  } wr_t;

  logic        o_sclk = 1'b0;
  logic        rst_n, o_sda, o_sda_dir;
  logic        sen0, sen1, sen2;
  logic        sda_out0, sda_oe0, wr_strobe0, frame_err0, dir_err0;
  logic        sda_out1, sda_oe1, wr_strobe1, frame_err1, dir_err1;
  logic        sda_out2, sda_oe2, wr_strobe2, frame_err2, dir_err2;
  logic [6:0]  wr_addr0, dbg_addr0, wr_addr1, dbg_addr1;
  logic [7:0]  wr_data0, dbg_data0, wr_data1, dbg_data1;
  logic [9:0]  wr_addr2, dbg_addr2;
  logic [15:0] wr_data2, dbg_data2;

  wr_t  exp_wr[$];
  wr_t  obs_wr[$];
  logic exp_rd[$];
  int   tests = 0;
  int   fails = 0;

  always #5 o_sclk = ~o_sclk;

  spi_reg_slave dut0 (
    .o_sclk(o_sclk), .rst_n(rst_n), .o_sen_n(sen0), .o_sda(o_sda), .o_sda_dir(o_sda_dir),
    .sda_out(sda_out0), .sda_oe(sda_oe0), .wr_strobe(wr_strobe0), .wr_addr(wr_addr0),
    .wr_data(wr_data0), .dbg_addr(dbg_addr0), .dbg_data(dbg_data0),
    .frame_err(frame_err0), .dir_err(dir_err0));

  spi_reg_slave #(.ADDR_DESC(1'b1), .RESET_VAL(8'hC3)) dut1 (
    .o_sclk(o_sclk), .rst_n(rst_n), .o_sen_n(sen1), .o_sda(o_sda), .o_sda_dir(o_sda_dir),
    .sda_out(sda_out1), .sda_oe(sda_oe1), .wr_strobe(wr_strobe1), .wr_addr(wr_addr1),
    .wr_data(wr_data1), .dbg_addr(dbg_addr1), .dbg_data(dbg_data1),
    .frame_err(frame_err1), .dir_err(dir_err1));

  spi_reg_slave #(.ADDR_W(10), .DATA_W(16), .RESET_VAL(16'h0000), .LSB_FIRST(1'b1)) dut2 (
    .o_sclk(o_sclk), .rst_n(rst_n), .o_sen_n(sen2), .o_sda(o_sda), .o_sda_dir(o_sda_dir),
    .sda_out(sda_out2), .sda_oe(sda_oe2), .wr_strobe(wr_strobe2), .wr_addr(wr_addr2),
    .wr_data(wr_data2), .dbg_addr(dbg_addr2), .dbg_data(dbg_data2),
    .frame_err(frame_err2), .dir_err(dir_err2));

  always @(negedge o_sclk) begin
    if (wr_strobe0) obs_wr.push_back(wr_t'{k: 2'd0, a: 16'(wr_addr0), d: 32'(wr_data0)});
    if (wr_strobe1) obs_wr.push_back(wr_t'{k: 2'd1, a: 16'(wr_addr1), d: 32'(wr_data1)});
    if (wr_strobe2) obs_wr.push_back(wr_t'{k: 2'd2, a: 16'(wr_addr2), d: 32'(wr_data2)});
  end

  task automatic set_sen(input int k, input logic v);
    case (k)
      0:       sen0 = v;
      1:       sen1 = v;
      default: sen2 = v;
    endcase
  endtask

  task automatic send(input int k, input logic [63:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge o_sclk);
      set_sen(k, 1'b0);
      o_sda = bits[i];
    end
  endtask

  task automatic end_frame(input int k);
    @(negedge o_sclk);
    set_sen(k, 1'b1);
    o_sda = 1'b0;
    @(negedge o_sclk);
    #1;
  endtask

  function automatic logic [31:0] rev(input logic [31:0] v, input int n);
    rev = '0;
    for (int i = 0; i < n; i++) rev[n-1-i] = v[i];
  endfunction

  task automatic test_reset();
    tests++;
    if ({sda_out0, sda_oe0, wr_strobe0, wr_addr0, wr_data0, frame_err0, dir_err0} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got oe=%b out=%b stb=%b a=%h d=%h fe=%b de=%b, expected all 0",
               sda_oe0, sda_out0, wr_strobe0, wr_addr0, wr_data0, frame_err0, dir_err0);
    end
    dbg_addr0 = 7'h0A; dbg_addr1 = 7'h05; #1;
    tests++;
    if (dbg_data0 !== 8'h00) begin fails++; $display("FAIL reset_mem0: got %h expected 00", dbg_data0); end
    tests++;
    if (dbg_data1 !== 8'hC3) begin fails++; $display("FAIL reset_val: got %h expected c3", dbg_data1); end
  endtask

  task automatic test_write();
    wr_t e, o;
    dbg_addr0 = 7'h0A;
    exp_wr.push_back(wr_t'{k: 2'd0, a: 16'h000A, d: 32'h55});
    send(0, 64'h0A55 >> 1, 15);
    @(negedge o_sclk); o_sda = 1'b1; #1;
    tests++;
    if (dbg_data0 !== 8'h00) begin fails++; $display("FAIL same_cycle_old: got %h expected 00", dbg_data0); end
    @(posedge o_sclk); #1;
    tests++;
    if (dbg_data0 !== 8'h55 || wr_strobe0 !== 1'b1) begin
      fails++; $display("FAIL write_commit: got dbg=%h stb=%b expected dbg=55 stb=1", dbg_data0, wr_strobe0);
    end
    end_frame(0);
    tests++;
    if (obs_wr.size() != exp_wr.size()) begin
      fails++; $display("FAIL write_count: got %0d strobes expected %0d", obs_wr.size(), exp_wr.size());
    end
    while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
      e = exp_wr.pop_front(); o = obs_wr.pop_front(); tests++;
      if (o !== e) begin fails++; $display("FAIL write_data: got %h expected %h", o, e); end
    end
    exp_wr.delete(); obs_wr.delete();
  endtask

  task automatic test_read();
    logic [7:0] v = 8'h55;
    logic b;
    o_sda_dir = 1'b1;
    for (int i = 7; i >= 0; i--) exp_rd.push_back(v[i]);
    send(0, 64'h8A, 8);
    for (int i = 0; i < 8; i++) begin
      @(negedge o_sclk); #1;
      b = exp_rd.pop_front(); tests++;
      if (sda_oe0 !== 1'b1 || sda_out0 !== b) begin
        fails++; $display("FAIL read_bit%0d: got oe=%b out=%b expected oe=1 out=%b", i, sda_oe0, sda_out0, b);
      end
    end
    @(posedge o_sclk);
    end_frame(0);
    tests++;
    if (sda_oe0 !== 1'b0 || sda_out0 !== 1'b0 || obs_wr.size() != 0 || frame_err0 !== 1'b0) begin
      fails++; $display("FAIL read_end: got oe=%b out=%b strobes=%0d fe=%b expected 0 0 0 0",
                        sda_oe0, sda_out0, obs_wr.size(), frame_err0);
    end
    obs_wr.delete();
  endtask

  task automatic test_stream();
    wr_t e, o;
    exp_wr.push_back(wr_t'{k: 2'd0, a: 16'h007F, d: 32'h11});
    exp_wr.push_back(wr_t'{k: 2'd0, a: 16'h0000, d: 32'h22});
    exp_wr.push_back(wr_t'{k: 2'd1, a: 16'h007F, d: 32'h11});
    exp_wr.push_back(wr_t'{k: 2'd1, a: 16'h007E, d: 32'h22});
    send(0, 64'h7F1122, 24); end_frame(0);
    send(1, 64'h7F1122, 24); end_frame(1);
    tests++;
    if (obs_wr.size() != exp_wr.size()) begin
      fails++; $display("FAIL stream_count: got %0d strobes expected %0d", obs_wr.size(), exp_wr.size());
    end
    while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
      e = exp_wr.pop_front(); o = obs_wr.pop_front(); tests++;
      if (o !== e) begin fails++; $display("FAIL stream_data: got %h expected %h", o, e); end
    end
    exp_wr.delete(); obs_wr.delete();
    dbg_addr0 = 7'h00; dbg_addr1 = 7'h7E; #1;
    tests++;
    if (dbg_data0 !== 8'h22 || dbg_data1 !== 8'h22) begin
      fails++; $display("FAIL stream_wrap: got mem0[00]=%h mem1[7e]=%h expected 22 22", dbg_data0, dbg_data1);
    end
  endtask

  task automatic test_back_to_back();
    wr_t e, o;
    logic [15:0] v = 16'hA1B2;
    logic b;
    exp_wr.push_back(wr_t'{k: 2'd0, a: 16'h0040, d: 32'hA1});
    exp_wr.push_back(wr_t'{k: 2'd0, a: 16'h0041, d: 32'hB2});
    exp_wr.push_back(wr_t'{k: 2'd0, a: 16'h0010, d: 32'hC3});
    send(0, 64'h40A1, 16); end_frame(0);
    send(0, 64'h41B2, 16); end_frame(0);
    send(0, 64'h10C3, 16); end_frame(0);
    tests++;
    if (obs_wr.size() != exp_wr.size()) begin
      fails++; $display("FAIL b2b_count: got %0d strobes expected %0d", obs_wr.size(), exp_wr.size());
    end
    while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
      e = exp_wr.pop_front(); o = obs_wr.pop_front(); tests++;
      if (o !== e) begin fails++; $display("FAIL b2b_data: got %h expected %h", o, e); end
    end
    exp_wr.delete(); obs_wr.delete();
    for (int i = 15; i >= 0; i--) exp_rd.push_back(v[i]);
    send(0, 64'hC0, 8);
    for (int i = 0; i < 16; i++) begin
      @(negedge o_sclk); #1;
      b = exp_rd.pop_front(); tests++;
      if (sda_out0 !== b) begin fails++; $display("FAIL stream_read_bit%0d: got %b expected %b", i, sda_out0, b); end
    end
    @(posedge o_sclk);
    end_frame(0);
  endtask

  task automatic test_wide();
    wr_t e, o;
    logic [15:0] d = 16'hA55A;
    logic [31:0] ar, dr;
    logic b;
    ar = rev(32'h2A5, 10);
    dr = rev(32'(d), 16);
    exp_wr.push_back(wr_t'{k: 2'd2, a: 16'h02A5, d: 32'hA55A});
    send(2, (64'(ar[9:0]) << 16) | 64'(dr[15:0]), 27);
    end_frame(2);
    tests++;
    if (obs_wr.size() != exp_wr.size()) begin
      fails++; $display("FAIL wide_count: got %0d strobes expected %0d", obs_wr.size(), exp_wr.size());
    end
    while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
      e = exp_wr.pop_front(); o = obs_wr.pop_front(); tests++;
      if (o !== e) begin fails++; $display("FAIL wide_data: got %h expected %h", o, e); end
    end
    exp_wr.delete(); obs_wr.delete();
    dbg_addr2 = 10'h2A5; #1;
    tests++;
    if (dbg_data2 !== 16'hA55A) begin fails++; $display("FAIL wide_mem: got %h expected a55a", dbg_data2); end
    for (int i = 0; i < 16; i++) exp_rd.push_back(d[i]);
    send(2, (64'd1 << 10) | 64'(ar[9:0]), 11);
    for (int i = 0; i < 16; i++) begin
      @(negedge o_sclk); #1;
      b = exp_rd.pop_front(); tests++;
      if (sda_oe2 !== 1'b1 || sda_out2 !== b) begin
        fails++; $display("FAIL wide_read_bit%0d: got oe=%b out=%b expected oe=1 out=%b", i, sda_oe2, sda_out2, b);
      end
    end
    @(posedge o_sclk);
    end_frame(2);
  endtask

  task automatic test_partial();
    wr_t e, o;
    dbg_addr0 = 7'h20;
    send(0, 64'h20FF >> 4, 12);
    end_frame(0);
    tests++;
    if (obs_wr.size() != 0 || dbg_data0 !== 8'h00 || frame_err0 !== 1'b0) begin
      fails++; $display("FAIL partial_discard: got strobes=%0d mem=%h fe=%b expected 0 00 0",
                        obs_wr.size(), dbg_data0, frame_err0);
    end
    obs_wr.delete();
    exp_wr.push_back(wr_t'{k: 2'd0, a: 16'h0021, d: 32'h3C});
    send(0, 64'h213C, 16);
    end_frame(0);
    tests++;
    if (frame_err0 !== 1'b1) begin fails++; $display("FAIL frame_err: got %b expected 1", frame_err0); end
    tests++;
    if (obs_wr.size() != exp_wr.size()) begin
      fails++; $display("FAIL partial_count: got %0d strobes expected %0d", obs_wr.size(), exp_wr.size());
    end
    while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
      e = exp_wr.pop_front(); o = obs_wr.pop_front(); tests++;
      if (o !== e) begin fails++; $display("FAIL partial_next_write: got %h expected %h", o, e); end
    end
    exp_wr.delete(); obs_wr.delete();
  endtask

  task automatic test_dir_err();
    int bad = 0;
    o_sda_dir = 1'b0;
    send(0, 64'h8A, 8);
    for (int i = 0; i < 8; i++) begin
      @(negedge o_sclk); #1;
      tests++;
      if (sda_oe0 !== 1'b0 || sda_out0 !== 1'b0) begin
        fails++; $display("FAIL dir_contention%0d: got oe=%b out=%b expected 0 0", i, sda_oe0, sda_out0);
      end
    end
    @(posedge o_sclk);
    end_frame(0);
    tests++;
    if (dir_err0 !== 1'b1) begin fails++; $display("FAIL dir_err: got %b expected 1", dir_err0); end
    @(negedge o_sclk); #2;
    rst_n = 1'b0; #1;
    tests++;
    if ({sda_out0, sda_oe0, wr_strobe0, wr_addr0, wr_data0, frame_err0, dir_err0} !== '0) begin
      fails++;
      $display("FAIL pulse_reset_outputs: got stb=%b a=%h d=%h fe=%b de=%b expected all 0",
               wr_strobe0, wr_addr0, wr_data0, frame_err0, dir_err0);
    end
    for (int a = 0; a < 128; a++) begin
      dbg_addr0 = 7'(a); #1;
      if (dbg_data0 !== 8'h00) bad++;
    end
    dbg_addr1 = 7'h7F; #1;
    tests++;
    if (bad != 0 || dbg_data1 !== 8'hC3) begin
      fails++; $display("FAIL pulse_reset_mem: got %0d nonzero regs, mem1[7f]=%h expected 0 c3", bad, dbg_data1);
    end
    @(negedge o_sclk);
    rst_n = 1'b1;
    o_sda_dir = 1'b1;
  endtask

  task automatic test_mid_reset();
    wr_t e, o;
    dbg_addr0 = 7'h33;
    send(0, 64'h33FF >> 6, 10);
    @(negedge o_sclk); #1;
    rst_n = 1'b0; #1;
    sen0 = 1'b1; #1;
    rst_n = 1'b1;
    @(negedge o_sclk); #1;
    tests++;
    if (obs_wr.size() != 0 || dbg_data0 !== 8'h00) begin
      fails++; $display("FAIL mid_reset_abort: got strobes=%0d mem=%h expected 0 00", obs_wr.size(), dbg_data0);
    end
    obs_wr.delete();
    exp_wr.push_back(wr_t'{k: 2'd0, a: 16'h0033, d: 32'h77});
    send(0, 64'h3377, 16);
    end_frame(0);
    tests++;
    if (frame_err0 !== 1'b0 || dbg_data0 !== 8'h77) begin
      fails++; $display("FAIL mid_reset_clean: got fe=%b mem=%h expected 0 77", frame_err0, dbg_data0);
    end
    tests++;
    if (obs_wr.size() != exp_wr.size()) begin
      fails++; $display("FAIL mid_reset_count: got %0d strobes expected %0d", obs_wr.size(), exp_wr.size());
    end
    while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
      e = exp_wr.pop_front(); o = obs_wr.pop_front(); tests++;
      if (o !== e) begin fails++; $display("FAIL mid_reset_write: got %h expected %h", o, e); end
    end
    exp_wr.delete(); obs_wr.delete();
  endtask

  initial begin
    rst_n = 1'b0; o_sda = 1'b0; o_sda_dir = 1'b1;
    sen0 = 1'b1; sen1 = 1'b1; sen2 = 1'b1;
    dbg_addr0 = '0; dbg_addr1 = '0; dbg_addr2 = '0;
    #22;
    @(negedge o_sclk);
    rst_n = 1'b1;
    @(negedge o_sclk); #1;
    test_reset();
    test_write();
    test_read();
    test_stream();
    test_back_to_back();
    test_wide();
    test_partial();
    test_dir_err();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
